b16_debug_ctrl: RTL and testbench

- Debug sequencer for the b16 core: owns the core's run line and the debug register port (dr, dw, daddr, din, dout, bp).
- A host agent issues halt, run, N-cycle step, register read/write, breakpoint set/clear and status commands over a valid/ready command channel, and receives exactly one response word per command.
- Sits between the host link (UART/JTAG bridge) and the cpu instance.

---
 rtl/b16_debug_ctrl_if.sv | 22 ++
 rtl/b16_debug_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_b16_debug_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/b16_debug_ctrl_if.sv
// rtl/b16_debug_ctrl_if.sv - host command/response channel of the b16 debug sequencer
interface b16_debug_ctrl_if #(parameter int L = 16);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [2:0]   cmd_reg;
  logic [L-1:0] cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [L-1:0] rsp_data;
  logic         rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_reg, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_reg, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/b16_debug_ctrl.sv
// rtl/b16_debug_ctrl.sv - b16 debug sequencer: run control, stepping, breakpoint, debug register port
module b16_debug_ctrl #(
  parameter bit START_RUN = 1'b1,
  parameter int L         = 16,
  parameter int SCNT      = 16
) (
  input  logic                   clk,
  input  logic                   nreset,
  b16_debug_ctrl_if.slave        host,
  output logic                   o_run,
  output logic                   o_dr,
  output logic                   o_dw,
  output logic [2:0]             o_daddr,
  output logic [L-1:0]           o_din,
  input  logic [L-1:0]           i_dout,
  output logic [L-1:0]           o_bp,
  input  logic [L-1:0]           i_cpu_addr,
  input  logic                   i_cpu_rd,
  output logic                   o_halted
);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_RESP} state_t;

  localparam logic [2:0] OP_HALT   = 3'd0;
  localparam logic [2:0] OP_RUN    = 3'd1;
  localparam logic [2:0] OP_STEP   = 3'd2;
  localparam logic [2:0] OP_READ   = 3'd3;
  localparam logic [2:0] OP_WRITE  = 3'd4;
  localparam logic [2:0] OP_SETBP  = 3'd5;
  localparam logic [2:0] OP_CLRBP  = 3'd6;
  localparam logic [2:0] OP_STATUS = 3'd7;

  state_t          r_state, w_state_n;
  logic            r_run_q, w_run_q_n;
  logic [L-1:0]    r_bp, w_bp_n;
  logic            r_bp_en, w_bp_en_n;
  logic            r_bp_hit, w_bp_hit_n;
  logic            r_skip, w_skip_n;
  logic            r_dr, w_dr_n;
  logic            r_dw, w_dw_n;
  logic [2:0]      r_daddr, w_daddr_n;
  logic [L-1:0]    r_din, w_din_n;
  logic            r_rsp_valid, w_rsp_valid_n;
  logic [L-1:0]    r_rsp_data, w_rsp_data_n;
  logic            r_rsp_err, w_rsp_err_n;
  logic [SCNT-1:0] r_cnt, w_cnt_n;

  logic            w_hit;
  logic            w_bp_event;
  logic            w_accept;
  logic [SCNT-1:0] w_cnt_dec;
  logic [SCNT-1:0] w_cnt_load;
  logic [L-1:0]    w_status;

  // The breakpoint suppresses run in the same cycle the matching read appears.
  assign w_hit      = r_bp_en & i_cpu_rd & (i_cpu_addr == r_bp) & ~r_skip;
  assign w_bp_event = w_hit & r_run_q;
  assign o_run      = r_run_q & ~w_hit;
  assign o_halted   = ~r_run_q;

  assign host.cmd_ready = (r_state == S_IDLE) & ~r_rsp_valid;
  assign host.rsp_valid = r_rsp_valid;
  assign host.rsp_data  = r_rsp_data;
  assign host.rsp_err   = r_rsp_err;

  assign o_dr    = r_dr;
  assign o_dw    = r_dw;
  assign o_daddr = r_daddr;
  assign o_din   = r_din;
  assign o_bp    = r_bp;

  assign w_accept   = host.cmd_valid & host.cmd_ready;
  assign w_cnt_dec  = r_cnt - SCNT'(1);
  assign w_cnt_load = (host.cmd_data == '0) ? SCNT'(1) : SCNT'(host.cmd_data);
  assign w_status   = {~r_run_q, r_bp_hit, r_bp_en, (r_state == S_STEP), {(L-4){1'b0}}};

  always_comb begin
    w_state_n     = r_state;
    w_run_q_n     = r_run_q;
    w_bp_n        = r_bp;
    w_bp_en_n     = r_bp_en;
    w_bp_hit_n    = r_bp_hit;
    w_skip_n      = r_skip;
    w_dr_n        = 1'b0;
    w_dw_n        = 1'b0;
    w_daddr_n     = r_daddr;
    w_din_n       = r_din;
    w_rsp_valid_n = r_rsp_valid;
    w_rsp_data_n  = r_rsp_data;
    w_rsp_err_n   = r_rsp_err;
    w_cnt_n       = r_cnt;

    // cpu-side events first; command handling below may override them
    if (o_run) w_skip_n = 1'b0;
    if (w_bp_event) begin
      w_run_q_n  = 1'b0;
      w_bp_hit_n = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_n     = S_RESP;
          w_rsp_valid_n = 1'b1;
          w_rsp_err_n   = 1'b0;
          w_rsp_data_n  = '0;
          case (host.cmd_op)
            OP_HALT: w_run_q_n = 1'b0;
            OP_RUN: begin
              if (!r_run_q || w_bp_event) begin
                w_run_q_n  = 1'b1;
                w_skip_n   = 1'b1;
                w_bp_hit_n = w_bp_event;
              end
            end
            OP_STEP: begin
              if (r_run_q) begin
                w_rsp_err_n = 1'b1;
              end else begin
                w_cnt_n       = w_cnt_load;
                w_skip_n      = 1'b1;
                w_run_q_n     = 1'b1;
                w_state_n     = S_STEP;
                w_rsp_valid_n = 1'b0;
              end
            end
            OP_READ: begin
              if (r_run_q) begin
                w_rsp_err_n = 1'b1;
              end else begin
                w_dr_n        = 1'b1;
                w_daddr_n     = host.cmd_reg;
                w_rsp_valid_n = 1'b0;
              end
            end
            OP_WRITE: begin
              if (r_run_q) begin
                w_rsp_err_n = 1'b1;
              end else begin
                w_dw_n    = 1'b1;
                w_daddr_n = host.cmd_reg;
                w_din_n   = host.cmd_data;
              end
            end
            OP_SETBP: begin
              w_bp_n    = host.cmd_data;
              w_bp_en_n = 1'b1;
            end
            OP_CLRBP: begin
              w_bp_en_n  = 1'b0;
              w_bp_hit_n = 1'b0;
            end
            default: w_rsp_data_n = w_status;
          endcase
        end
      end
      S_STEP: begin
        if (w_bp_event) begin
          w_state_n     = S_RESP;
          w_rsp_valid_n = 1'b1;
          w_rsp_data_n  = L'(r_cnt);
        end else if (o_run) begin
          w_cnt_n = w_cnt_dec;
          if (w_cnt_dec == '0) begin
            w_run_q_n     = 1'b0;
            w_state_n     = S_RESP;
            w_rsp_valid_n = 1'b1;
            w_rsp_data_n  = '0;
          end
        end
      end
      S_RESP: begin
        // a read holds back the response until dout has been sampled
        if (r_dr) begin
          w_rsp_data_n  = i_dout;
          w_rsp_valid_n = 1'b1;
        end else if (r_rsp_valid && host.rsp_ready) begin
          w_rsp_valid_n = 1'b0;
          w_state_n     = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= S_IDLE;
      r_run_q     <= START_RUN;
      r_bp        <= '0;
      r_bp_en     <= 1'b0;
      r_bp_hit    <= 1'b0;
      r_skip      <= 1'b0;
      r_dr        <= 1'b0;
      r_dw        <= 1'b0;
      r_daddr     <= '0;
      r_din       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_n;
      r_run_q     <= w_run_q_n;
      r_bp        <= w_bp_n;
      r_bp_en     <= w_bp_en_n;
      r_bp_hit    <= w_bp_hit_n;
      r_skip      <= w_skip_n;
      r_dr        <= w_dr_n;
      r_dw        <= w_dw_n;
      r_daddr     <= w_daddr_n;
      r_din       <= w_din_n;
      r_rsp_valid <= w_rsp_valid_n;
      r_rsp_data  <= w_rsp_data_n;
      r_rsp_err   <= w_rsp_err_n;
      r_cnt       <= w_cnt_n;
    end
  end

endmodule

// File: tb/tb_b16_debug_ctrl.sv
// tb/tb_b16_debug_ctrl.sv - randomized self-checking bench for b16_debug_ctrl with a simple core model
module tb_b16_debug_ctrl;
  localparam int L = 16;
  localparam logic [2:0] OP_HALT = 3'd0, OP_RUN = 3'd1, OP_STEP = 3'd2, OP_READ = 3'd3;
  localparam logic [2:0] OP_WRITE = 3'd4, OP_SETBP = 3'd5, OP_CLRBP = 3'd6, OP_STATUS = 3'd7;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  b16_debug_ctrl_if #(.L(L)) host();

  logic         run, dr, dw, halted, cpu_rd;
  logic [2:0]   daddr;
  logic [L-1:0] din, dout, bp, cpu_addr;

  b16_debug_ctrl #(.START_RUN(1'b1), .L(L), .SCNT(16)) dut (
    .clk(clk), .nreset(nreset), .host(host),
    .o_run(run), .o_dr(dr), .o_dw(dw), .o_daddr(daddr), .o_din(din),
    .i_dout(dout), .o_bp(bp), .i_cpu_addr(cpu_addr), .i_cpu_rd(cpu_rd), .o_halted(halted)
  );

  // core model: reg 4 is P, one fetch per cycle while run is high
  logic [L-1:0] regs [8];
  assign dout     = regs[daddr];
  assign cpu_addr = regs[4];
  assign cpu_rd   = 1'b1;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'(i * 32'h1111);
    end else begin
      if (run) regs[4] <= regs[4] + 16'd1;
      if (dw) regs[daddr] <= din;
    end
  end

  int n_checks = 0, n_fail = 0;
  int n_run = 0, n_dr = 0, n_dw = 0, n_bad = 0;
  logic [2:0]   dr_addr, dw_addr;
  logic [L-1:0] dw_data;

  always @(negedge clk) begin
    if (nreset) begin
      if (run) n_run++;
      if (dr) begin n_dr++; dr_addr = daddr; end
      if (dw) begin n_dw++; dw_addr = daddr; dw_data = din; end
      if ((dr && dw) || ((dr || dw) && run) || (run && halted)) n_bad++;
    end
  end

  // reference state derived from the commands issued
  logic [L-1:0] exp_regs [8];
  logic         bp_en_m, bp_hit_m;
  logic [L-1:0] bp_m;
  logic [L-1:0] rsp;
  logic         err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [2:0] rg, input logic [L-1:0] d,
                        input int hold, output logic [L-1:0] rd, output logic re);
    int t;
    @(negedge clk);
    host.cmd_op = op; host.cmd_reg = rg; host.cmd_data = d; host.cmd_valid = 1'b1;
    t = 0;
    while (!host.cmd_ready && t < 50) begin @(negedge clk); t++; end
    check("cmd_ready_wait", 32'(t < 50), 32'd1);
    @(posedge clk); #1;
    host.cmd_valid = 1'b0;
    @(negedge clk);
    t = 0;
    while (!host.rsp_valid && t < 400) begin @(negedge clk); t++; end
    check("rsp_valid_wait", 32'(t < 400), 32'd1);
    rd = host.rsp_data;
    re = host.rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(host.rsp_valid), 32'd1);
      check("hold_data", 32'(host.rsp_data), 32'(rd));
      check("hold_err", 32'(host.rsp_err), 32'(re));
      check("hold_cmd_ready", 32'(host.cmd_ready), 32'd0);
    end
    host.rsp_ready = 1'b1;
    @(posedge clk); #1;
    host.rsp_ready = 1'b0;
    check("rsp_released", 32'(host.rsp_valid), 32'd0);
  endtask

  task automatic wrt_reg(input logic [2:0] rg, input logic [L-1:0] d);
    int dw0, dr0, r0;
    dw0 = n_dw; dr0 = n_dr; r0 = n_run;
    do_cmd(OP_WRITE, rg, d, 0, rsp, err);
    check("wr_rsp", 32'(rsp), 32'd0);
    check("wr_err", 32'(err), 32'd0);
    check("wr_dw_pulses", 32'(n_dw - dw0), 32'd1);
    check("wr_dr_pulses", 32'(n_dr - dr0), 32'd0);
    check("wr_daddr", 32'(dw_addr), 32'(rg));
    check("wr_din", 32'(dw_data), 32'(d));
    check("wr_no_run", 32'(n_run - r0), 32'd0);
    exp_regs[rg] = d;
  endtask

  task automatic rd_reg(input logic [2:0] rg);
    int dr0, dw0;
    dr0 = n_dr; dw0 = n_dw;
    do_cmd(OP_READ, rg, 16'h0, 0, rsp, err);
    check("rd_data", 32'(rsp), 32'(exp_regs[rg]));
    check("rd_err", 32'(err), 32'd0);
    check("rd_dr_pulses", 32'(n_dr - dr0), 32'd1);
    check("rd_dw_pulses", 32'(n_dw - dw0), 32'd0);
    check("rd_daddr", 32'(dr_addr), 32'(rg));
  endtask

  task automatic simple_cmd(input string tag, input logic [2:0] op, input logic [L-1:0] d);
    do_cmd(op, 3'd0, d, 0, rsp, err);
    check(tag, {15'd0, err, rsp}, 32'd0);
  endtask

  task automatic status_chk(input string tag);
    do_cmd(OP_STATUS, 3'd0, 16'h0, 0, rsp, err);
    check(tag, {15'd0, err, rsp}, {16'd0, halted, bp_hit_m, bp_en_m, 13'd0});
  endtask

  // Expected STEP outcome: the first cycle is exempt from the breakpoint,
  // a hit in cycle k (k < N) stops after k executed cycles with N-k left.
  task automatic step_cmd(input int n, output logic [L-1:0] got);
    int eff, k, r0;
    logic [L-1:0] a;
    eff = (n == 0) ? 1 : n;
    k = eff;
    if (bp_en_m) begin
      for (int j = 1; j < eff; j++) begin
        a = exp_regs[4] + 16'(j);
        if (a == bp_m) begin k = j; break; end
      end
    end
    r0 = n_run;
    do_cmd(OP_STEP, 3'd0, 16'(n), 0, got, err);
    check("step_rsp", 32'(got), 32'(eff - k));
    check("step_err", 32'(err), 32'd0);
    check("step_cycles", 32'(n_run - r0), 32'(k));
    check("step_halted", 32'(halted), 32'd1);
    if (k < eff) bp_hit_m = 1'b1;
    exp_regs[4] = exp_regs[4] + 16'(k);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, r0, dr0, sel;
    logic [L-1:0] v;
    host.cmd_valid = 1'b0; host.cmd_op = 3'd0; host.cmd_reg = 3'd0;
    host.cmd_data = '0; host.rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) exp_regs[i] = 16'(i * 32'h1111);
    bp_en_m = 1'b0; bp_hit_m = 1'b0; bp_m = '0;

    repeat (3) @(negedge clk);
    check("rst_dr", 32'(dr), 32'd0);
    check("rst_dw", 32'(dw), 32'd0);
    check("rst_rsp_valid", 32'(host.rsp_valid), 32'd0);
    check("rst_bp", 32'(bp), 32'd0);
    nreset = 1'b1;
    @(negedge clk);
    check("rst_run", 32'(run), 32'd1);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_cmd_ready", 32'(host.cmd_ready), 32'd1);
    check("rst_daddr", 32'(daddr), 32'd0);
    status_chk("status_reset");

    simple_cmd("halt_rsp", OP_HALT, 16'h0);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_run", 32'(run), 32'd0);
    wrt_reg(3'd4, 16'h3FFE);
    rd_reg(3'd4);
    wrt_reg(3'd5, 16'hBEEF);
    rd_reg(3'd5);

    // breakpoint while free running
    wrt_reg(3'd4, 16'h0000);
    simple_cmd("setbp_rsp", OP_SETBP, 16'h0010);
    bp_en_m = 1'b1; bp_m = 16'h0010;
    r0 = n_run;
    simple_cmd("run_rsp", OP_RUN, 16'h0);
    t = 0;
    while (!halted && t < 200) begin @(negedge clk); t++; end
    check("bp_halt", 32'(halted), 32'd1);
    @(posedge clk); #1;
    check("bp_p", 32'(regs[4]), 32'h0010);
    check("bp_cycles", 32'(n_run - r0), 32'd16);
    bp_hit_m = 1'b1;
    status_chk("status_bp");
    check("status_bp_const", 32'(rsp), 32'hE000);
    simple_cmd("rerun_rsp", OP_RUN, 16'h0);
    bp_hit_m = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("bp_pass_running", 32'(halted), 32'd0);
    check("bp_pass_p", 32'(regs[4] > 16'h0010), 32'd1);
    simple_cmd("halt2_rsp", OP_HALT, 16'h0);
    wrt_reg(3'd4, 16'h1000);
    simple_cmd("clrbp_rsp", OP_CLRBP, 16'h0);
    bp_en_m = 1'b0;
    status_chk("status_clr");

    step_cmd(5, rsp);
    step_cmd(0, rsp);
    v = exp_regs[4] + 16'd3;
    simple_cmd("setbp3_rsp", OP_SETBP, v);
    bp_en_m = 1'b1; bp_m = v;
    step_cmd(100, rsp);
    check("step100_rsp", 32'(rsp), 32'd97);
    status_chk("status_step_hit");
    rd_reg(3'd4);

    // commands rejected while running, with a stalled response
    simple_cmd("clrbp2_rsp", OP_CLRBP, 16'h0);
    bp_en_m = 1'b0; bp_hit_m = 1'b0;
    simple_cmd("run2_rsp", OP_RUN, 16'h0);
    dr0 = n_dr;
    do_cmd(OP_READ, 3'd2, 16'h0, 4, rsp, err);
    check("run_rd_err", {15'd0, err, rsp}, 32'h0001_0000);
    check("run_rd_no_dr", 32'(n_dr - dr0), 32'd0);
    do_cmd(OP_STEP, 3'd0, 16'd3, 0, rsp, err);
    check("run_step_err", {15'd0, err, rsp}, 32'h0001_0000);
    do_cmd(OP_WRITE, 3'd6, 16'h5A5A, 0, rsp, err);
    check("run_wr_err", {15'd0, err, rsp}, 32'h0001_0000);
    check("run_still_running", 32'(halted), 32'd0);
    simple_cmd("halt3_rsp", OP_HALT, 16'h0);
    wrt_reg(3'd4, 16'($urandom));
    rd_reg(3'd6);

    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: wrt_reg(3'($urandom_range(0, 7)), 16'($urandom));
        1: rd_reg(3'($urandom_range(0, 7)));
        2: begin
          v = exp_regs[4] + 16'($urandom_range(1, 12));
          simple_cmd("rnd_setbp", OP_SETBP, v);
          bp_en_m = 1'b1; bp_m = v;
        end
        3: begin
          simple_cmd("rnd_clrbp", OP_CLRBP, 16'h0);
          bp_en_m = 1'b0; bp_hit_m = 1'b0;
        end
        4: step_cmd($urandom_range(0, 15), rsp);
        default: status_chk("rnd_status");
      endcase
    end
    rd_reg(3'd4);

    check("protocol_violations", 32'(n_bad), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
